// File: rtl/salamander_wide_prom.sv
// salamander_wide_prom: downloadable PROM with byte-lane word assembly and NRD registered read ports
module salamander_wide_prom #(
    parameter int AW         = 10,
    parameter int DW         = 16,
    parameter int NRD        = 2,
    parameter     SIMHEXFILE = "",
    localparam int NB        = DW / 8,
    localparam int BW        = $clog2(NB),
    localparam int CW        = AW + BW + 1
) (
    input  logic                i_MCLK,
    input  logic                i_RST_n,
    input  logic [AW+BW-1:0]    i_PROG_ADDR,
    input  logic [7:0]          i_PROG_DIN,
    input  logic                i_PROG_CS,
    input  logic                i_PROG_WR,
    input  logic [NRD*AW-1:0]   i_ADDR,
    input  logic [NRD-1:0]      i_RD,
    output logic [NRD*DW-1:0]   o_DOUT,
    output logic                o_READY,
    output logic [7:0]          o_CKSUM,
    output logic [CW-1:0]       o_BYTECNT
);
    localparam int LW = BW > 0 ? BW : 1;
    typedef enum logic [1:0] {EMPTY, LOAD, READY} state_t;
    state_t state_q, state_d;
    logic [DW-1:0] mem [2**AW];
    logic [DW-1:0] asm_q, asm_d;
    logic [7:0] cksum_q, cksum_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic wr, fresh, commit;
    logic [LW-1:0] lane;
    logic [AW-1:0] waddr;
    assign wr = i_PROG_CS & i_PROG_WR;
    assign fresh = wr && state_q != LOAD;
    assign lane = BW > 0 ? LW'(i_PROG_ADDR) : '0;
    assign waddr = AW'(i_PROG_ADDR >> BW);
    assign commit = wr && int'(lane) == NB - 1;
    always_ff @(posedge i_MCLK or negedge i_RST_n)
        if (!i_RST_n) state_q <= EMPTY;
        else state_q <= state_d;
    always_comb begin
        state_d = state_q;
        if (state_q == LOAD) state_d = i_PROG_CS ? LOAD : READY;
        else if (wr) state_d = LOAD;
    end
    always_comb begin
        o_READY = state_q == READY;
    end
    always_comb begin
        asm_d = fresh ? '0 : asm_q;
        cksum_d = fresh ? '0 : cksum_q;
        cnt_d = fresh ? '0 : cnt_q;
        if (wr) begin
            if (int'(lane) < NB) asm_d[8*int'(lane) +: 8] = i_PROG_DIN;
            cksum_d = cksum_d + i_PROG_DIN;
            cnt_d = &cnt_d ? cnt_d : cnt_d + 1'b1;
        end
    end
    always_ff @(posedge i_MCLK or negedge i_RST_n)
        if (!i_RST_n) begin
            asm_q <= '0;
            cksum_q <= '0;
            cnt_q <= '0;
        end else begin
            asm_q <= asm_d;
            cksum_q <= cksum_d;
            cnt_q <= cnt_d;
        end
    always_ff @(posedge i_MCLK)
        if (commit) mem[waddr] <= asm_d;
    assign o_CKSUM = cksum_q;
    assign o_BYTECNT = cnt_q;
    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [DW-1:0] dout_q;
        always_ff @(posedge i_MCLK or negedge i_RST_n)
            if (!i_RST_n) dout_q <= '0;
            else if (state_q != LOAD && i_RD[k] && !wr) dout_q <= mem[i_ADDR[k*AW +: AW]];
        assign o_DOUT[k*DW +: DW] = dout_q;
    end
endmodule

// File: tb/tb_salamander_wide_prom.sv
// tb_salamander_wide_prom: directed load/read sequences checked against a byte-level PROM model
module tb_salamander_wide_prom;
    localparam int AW = 10, DW = 16, NRD = 2, NB = 2, BW = 1, CW = AW + BW + 1;
    logic clk = 1'b0, rst_n = 1'b1, cs = 1'b0, wr = 1'b0;
    logic [AW+BW-1:0] pa = '0;
    logic [7:0] din = '0;
    logic [NRD*AW-1:0] addr = '0;
    logic [NRD-1:0] rd = '0;
    logic [NRD*DW-1:0] dout;
    logic ready;
    logic [7:0] ck;
    logic [CW-1:0] cnt;
    int checks = 0, failures = 0;
    always #5 clk = ~clk;
    salamander_wide_prom #(.AW(AW), .DW(DW), .NRD(NRD)) dut (
        .i_MCLK(clk), .i_RST_n(rst_n), .i_PROG_ADDR(pa), .i_PROG_DIN(din),
        .i_PROG_CS(cs), .i_PROG_WR(wr), .i_ADDR(addr), .i_RD(rd),
        .o_DOUT(dout), .o_READY(ready), .o_CKSUM(ck), .o_BYTECNT(cnt)
    );
    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask
    // Model: byte-addressed download into a word image, totals per download, read results per port
    logic [DW-1:0] rom [2**AW];
    bit known [2**AW];
    logic [7:0] lanes [NB];
    bit m_load, m_ready;
    int m_ck, m_cnt, ma;
    logic [DW-1:0] m_dout [NRD];
    bit m_dv [NRD];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_load = 0; m_ready = 0; m_ck = 0; m_cnt = 0;
            foreach (lanes[i]) lanes[i] = 8'h00;
            foreach (m_dout[k]) begin m_dout[k] = '0; m_dv[k] = 1; end
        end else begin
            if (!m_load && !(cs && wr))
                for (int k = 0; k < NRD; k++)
                    if (rd[k]) begin
                        ma = int'(addr[k*AW +: AW]);
                        m_dout[k] = rom[ma];
                        m_dv[k] = known[ma];
                    end
            if (cs && wr) begin
                if (!m_load) begin
                    m_ck = 0; m_cnt = 0;
                    foreach (lanes[i]) lanes[i] = 8'h00;
                end
                lanes[int'(pa) % NB] = din;
                m_ck = (m_ck + int'(din)) % 256;
                if (m_cnt < 2**CW - 1) m_cnt++;
                if (int'(pa) % NB == NB - 1) begin
                    rom[int'(pa) / NB] = {lanes[1], lanes[0]};
                    known[int'(pa) / NB] = 1;
                end
                m_load = 1; m_ready = 0;
            end else if (m_load && !cs) begin
                m_load = 0; m_ready = 1;
            end
        end
    end
    always @(negedge clk)
        if (rst_n) begin
            chk("ready", 64'(ready), 64'(m_ready));
            chk("cksum", 64'(ck), 64'(m_ck));
            chk("bytecnt", 64'(cnt), 64'(m_cnt));
            for (int k = 0; k < NRD; k++)
                if (m_dv[k]) chk($sformatf("dout%0d", k), 64'(dout[k*DW +: DW]), 64'(m_dout[k]));
        end
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic wb(input int a, input int d);
        cs = 1; wr = 1; pa = (AW+BW)'(a); din = 8'(d);
        tick();
        wr = 0;
    endtask
    initial begin
        #1 rst_n = 0;
        repeat (3) tick();
        chk("rst_ready", 64'(ready), 0);
        chk("rst_dout", 64'(dout), 0);
        chk("rst_cksum", 64'(ck), 0);
        chk("rst_bytecnt", 64'(cnt), 0);
        rst_n = 1;
        tick();
        wb(0, 'h34); wb(1, 'h12); cs = 0;
        tick();
        chk("t2_ready", 64'(ready), 1);
        chk("t2_cksum", 64'(ck), 'h46);
        chk("t2_bytecnt", 64'(cnt), 2);
        rd = 2'b01; addr = '0;
        tick();
        chk("t2_dout", 64'(dout[15:0]), 'h1234);
        rd = 0;
        wb(6, 'hEF); wb(7, 'hBE); wb(14, 'hFE); wb(15, 'hCA); wb(10, 'h57); wb(11, 'h13); cs = 0;
        tick();
        addr = {10'd7, 10'd3}; rd = 2'b11;
        tick();
        chk("t3_p0", 64'(dout[15:0]), 'hBEEF);
        chk("t3_p1", 64'(dout[31:16]), 'hCAFE);
        rd = 0;
        tick();
        chk("t3_hold", 64'(dout), 'hCAFE_BEEF);
        chk("t3_cksum", 64'(ck), 'hDF);
        chk("t3_bytecnt", 64'(cnt), 6);
        wb(10, 'hAA); wb(13, 'hBB); cs = 0;
        tick();
        chk("t4_cksum", 64'(ck), 'h65);
        addr = {10'd5, 10'd6}; rd = 2'b11;
        tick();
        chk("t4_word6", 64'(dout[15:0]), 'hBBAA);
        chk("t4_word5", 64'(dout[31:16]), 'h1357);
        rd = 2'b01; addr = '0;
        wb(0, 'hFF); wb(1, 'h02);
        tick();
        chk("t5_load_hold", 64'(dout[15:0]), 'hBBAA);
        chk("t5_cksum", 64'(ck), 'h01);
        cs = 0;
        tick();
        chk("t5_ready", 64'(ready), 1);
        wb(2, 'h11);
        chk("t5_drop", 64'(dout[15:0]), 'hBBAA);
        chk("t5_reload", 64'(ready), 0);
        chk("t5_restart_cnt", 64'(cnt), 1);
        cs = 0;
        tick();
        tick();
        chk("t5_word0", 64'(dout[15:0]), 'h02FF);
        rd = 0;
        wb(8, 'h21); wb(9, 'h43); wb(10, 'h65);
        #2 rst_n = 0;
        #1;
        chk("t6_ready", 64'(ready), 0);
        chk("t6_cksum", 64'(ck), 0);
        chk("t6_bytecnt", 64'(cnt), 0);
        chk("t6_dout", 64'(dout), 0);
        tick();
        rst_n = 1;
        tick();
        wb(2, 'h78); wb(3, 'h56); cs = 0;
        tick();
        chk("t6_new_cnt", 64'(cnt), 2);
        chk("t6_new_cksum", 64'(ck), 'hCE);
        addr = {10'd4, 10'd1}; rd = 2'b11;
        tick();
        chk("t6_word1", 64'(dout[15:0]), 'h5678);
        chk("t6_word4", 64'(dout[31:16]), 'h4321);
        rd = 0;
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
